smem_store_unit: RTL and testbench

- Storage responder for backward-extension stage 1.
- Holds two per-read interval buffers:
  - curr: candidate intervals written at the descending current_wr_addr.
  - mem: finished SMEM intervals written at the ascending mem_wr_addr.
- Serves stage-1 read requests (current_rd_addr) with 1-cycle registered data.
- On request, drains the mem buffer to the host side as 512-bit cache lines through a valid/ready handshake.

---
 rtl/smem_pkg.sv | 26 ++
 rtl/smem_entry_ram.sv | 42 ++++
 rtl/smem_store_unit.sv | 179 +++++++++++++++++
 tb/tb_smem_store_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/smem_pkg.sv
// Shared types and constants for the SMEM backward-extension store path.
// Entries are 256 bits with x0 in the low word; drain lines carry two entries.
package smem_pkg;

   localparam int ADDR_W         = 7;
   localparam int DEPTH          = 1 << ADDR_W;
   localparam int READ_NUM_WIDTH = 6;
   localparam int CL             = 512;
   localparam int MAX_READ       = 64;

   typedef struct packed {
      logic [63:0] info;
      logic [63:0] x2;
      logic [63:0] x1;
      logic [63:0] x0;
   } entry_t;

   typedef enum logic [2:0] {
      F_INIT, F_RUN, F_BREAK, BCK_INI, BCK_RUN, BCK_END, BUBBLE
   } stage_status_e;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_SEND, S_DONE
   } drain_state_e;

endpackage

// File: rtl/smem_entry_ram.sv
// Entry buffer: one write port, one registered read port (1 cycle), write-first bypass.
// Read register holds its value while rd_en is low; no backpressure.
module smem_entry_ram
   import smem_pkg::*;
#(
   parameter int AW = ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  entry_t        wr_dat,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output entry_t        rd_dat
);

   entry_t mem_q [0:(1 << AW) - 1];
   entry_t rd_dat_q, rd_dat_d;

   always_comb begin
      rd_dat_d = rd_dat_q;
      if (rd_en) begin
         rd_dat_d = (wr_en && (wr_addr == rd_addr)) ? wr_dat : mem_q[rd_addr];
      end
   end

   // Array contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_dat;
      end
      if (rst) begin
         rd_dat_q <= '0;
      end else begin
         rd_dat_q <= rd_dat_d;
      end
   end

   assign rd_dat = rd_dat_q;

endmodule

// File: rtl/smem_store_unit.sv
// Curr/mem interval buffers: stage-1 reads return in 1 cycle (frozen by stall);
// mem drains as 512-bit lines, each held on out_valid until out_ready, one line per 3+ cycles.
module smem_store_unit
   import smem_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic                      store_valid_curr,
   input  logic [63:0]               curr_x_0,
   input  logic [63:0]               curr_x_1,
   input  logic [63:0]               curr_x_2,
   input  logic [63:0]               curr_x_info,
   input  logic [ADDR_W-1:0]         curr_x_addr,
   input  logic                      store_valid_mem,
   input  logic [63:0]               mem_x_0,
   input  logic [63:0]               mem_x_1,
   input  logic [63:0]               mem_x_2,
   input  logic [63:0]               mem_x_info,
   input  logic [ADDR_W-1:0]         mem_x_addr,
   input  logic                      rd_req,
   input  logic [READ_NUM_WIDTH-1:0] rd_read_num,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [63:0]               rd_x0,
   output logic [63:0]               rd_x1,
   output logic [63:0]               rd_x2,
   output logic [63:0]               rd_info,
   output logic                      rd_valid,
   output logic [READ_NUM_WIDTH-1:0] rd_read_num_o,
   input  logic                      clear_mem,
   input  logic                      drain_start,
   input  logic [READ_NUM_WIDTH-1:0] drain_read_num,
   output logic                      out_valid,
   output logic [CL-1:0]             out_data,
   output logic                      out_last,
   output logic [READ_NUM_WIDTH-1:0] out_read_num,
   input  logic                      out_ready,
   output logic                      drain_busy,
   output logic                      drain_done
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int BA_W  = ADDR_W - 1;

   entry_t curr_wr, mem_wr, curr_rd, even_rd, odd_rd, upper;
   logic   rd_en, fetch_en;

   drain_state_e              state_q, state_d;
   logic [CNT_W-1:0]          mem_cnt_q, mem_cnt_d, mem_wr_top;
   logic [CNT_W-1:0]          cnt_q, cnt_d, ptr_q, ptr_d;
   logic [READ_NUM_WIDTH-1:0] tag_q, tag_d, rd_num_q, rd_num_d;
   logic                      rd_valid_q, rd_valid_d;
   logic                      out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [CL-1:0]             out_data_q, out_data_d;
   logic                      busy_q, busy_d, done_q, done_d;

   assign curr_wr  = '{info: curr_x_info, x2: curr_x_2, x1: curr_x_1, x0: curr_x_0};
   assign mem_wr   = '{info: mem_x_info, x2: mem_x_2, x1: mem_x_1, x0: mem_x_0};
   assign rd_en    = rd_req & ~stall;
   assign fetch_en = (state_q == S_FETCH);

   smem_entry_ram #(.AW(ADDR_W)) u_curr (
      .clk(clk), .rst(rst), .wr_en(store_valid_curr), .wr_addr(curr_x_addr), .wr_dat(curr_wr),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_dat(curr_rd)
   );

   // mem is split by address LSB so an entry pair is fetched in one cycle.
   smem_entry_ram #(.AW(BA_W)) u_mem_even (
      .clk(clk), .rst(rst), .wr_en(store_valid_mem & ~mem_x_addr[0]),
      .wr_addr(mem_x_addr[ADDR_W-1:1]), .wr_dat(mem_wr),
      .rd_en(fetch_en), .rd_addr(ptr_q[ADDR_W-1:1]), .rd_dat(even_rd)
   );

   smem_entry_ram #(.AW(BA_W)) u_mem_odd (
      .clk(clk), .rst(rst), .wr_en(store_valid_mem & mem_x_addr[0]),
      .wr_addr(mem_x_addr[ADDR_W-1:1]), .wr_dat(mem_wr),
      .rd_en(fetch_en), .rd_addr(ptr_q[ADDR_W-1:1]), .rd_dat(odd_rd)
   );

   assign mem_wr_top = CNT_W'(mem_x_addr) + CNT_W'(1);

   always_comb begin
      mem_cnt_d = (clear_mem || (state_q == S_DONE)) ? '0 : mem_cnt_q;
      if (store_valid_mem && (mem_wr_top > mem_cnt_d)) begin
         mem_cnt_d = mem_wr_top;
      end

      rd_valid_d = stall ? rd_valid_q : rd_req;
      rd_num_d   = rd_en ? rd_read_num : rd_num_q;

      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      tag_d       = tag_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      upper       = (ptr_q + CNT_W'(1) < cnt_q) ? odd_rd : entry_t'('0);

      case (state_q)
         S_IDLE: begin
            if (drain_start) begin
               cnt_d   = mem_cnt_q;
               tag_d   = drain_read_num;
               ptr_d   = '0;
               busy_d  = 1'b1;
               state_d = (mem_cnt_q == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            out_data_d  = {upper, even_rd};
            out_last_d  = (ptr_q + CNT_W'(2) >= cnt_q);
            out_valid_d = 1'b1;
            state_d     = S_SEND;
         end
         S_SEND: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               ptr_d       = ptr_q + CNT_W'(2);
               state_d     = out_last_q ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mem_cnt_q   <= '0;
         cnt_q       <= '0;
         ptr_q       <= '0;
         tag_q       <= '0;
         rd_valid_q  <= 1'b0;
         rd_num_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_cnt_q   <= mem_cnt_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         tag_q       <= tag_d;
         rd_valid_q  <= rd_valid_d;
         rd_num_q    <= rd_num_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rd_x0         = curr_rd.x0;
   assign rd_x1         = curr_rd.x1;
   assign rd_x2         = curr_rd.x2;
   assign rd_info       = curr_rd.info;
   assign rd_valid      = rd_valid_q;
   assign rd_read_num_o = rd_num_q;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_last      = out_last_q;
   assign out_read_num  = tag_q;
   assign drain_busy    = busy_q;
   assign drain_done    = done_q;

endmodule

// File: tb/tb_smem_store_unit.sv
// Scoreboarded bench for smem_store_unit: read-path latency/stall/bypass and mem drain lines.
module tb_smem_store_unit;
   import smem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, stall, store_valid_curr, store_valid_mem, rd_req, rd_valid;
   logic [63:0] curr_x_0, curr_x_1, curr_x_2, curr_x_info;
   logic [63:0] mem_x_0, mem_x_1, mem_x_2, mem_x_info;
   logic [63:0] rd_x0, rd_x1, rd_x2, rd_info;
   logic [ADDR_W-1:0] curr_x_addr, mem_x_addr, rd_addr;
   logic [READ_NUM_WIDTH-1:0] rd_read_num, rd_read_num_o, drain_read_num, out_read_num;
   logic clear_mem, drain_start, out_valid, out_last, out_ready, drain_busy, drain_done;
   logic [CL-1:0] out_data;

   smem_store_unit dut (
      .clk(clk), .rst(rst), .stall(stall),
      .store_valid_curr(store_valid_curr), .curr_x_0(curr_x_0), .curr_x_1(curr_x_1),
      .curr_x_2(curr_x_2), .curr_x_info(curr_x_info), .curr_x_addr(curr_x_addr),
      .store_valid_mem(store_valid_mem), .mem_x_0(mem_x_0), .mem_x_1(mem_x_1),
      .mem_x_2(mem_x_2), .mem_x_info(mem_x_info), .mem_x_addr(mem_x_addr),
      .rd_req(rd_req), .rd_read_num(rd_read_num), .rd_addr(rd_addr),
      .rd_x0(rd_x0), .rd_x1(rd_x1), .rd_x2(rd_x2), .rd_info(rd_info),
      .rd_valid(rd_valid), .rd_read_num_o(rd_read_num_o),
      .clear_mem(clear_mem), .drain_start(drain_start), .drain_read_num(drain_read_num),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_read_num(out_read_num), .out_ready(out_ready),
      .drain_busy(drain_busy), .drain_done(drain_done)
   );

   typedef struct packed {
      logic [CL-1:0]             dat;
      logic                      last;
      logic [READ_NUM_WIDTH-1:0] tag;
   } line_t;

   int     n_chk = 0;
   int     n_err = 0;
   int     hs_cnt = 0;
   int     hs0;
   bit     seen;
   line_t  line_q[$];
   entry_t rd_q[$];
   line_t  mon_e;
   entry_t e1, e2, e3;

   task automatic check(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic entry_t mk(input logic [63:0] b);
      return '{info: b + 64'h300, x2: b + 64'h200, x1: b + 64'h100, x0: b};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int n, output bit got);
      got = 1'b0;
      for (int i = 0; i < n && !got; i++) begin
         step();
         got = drain_done;
      end
   endtask

   task automatic set_curr(input logic [ADDR_W-1:0] a, input entry_t e);
      store_valid_curr = 1'b1;
      curr_x_addr = a;
      {curr_x_info, curr_x_2, curr_x_1, curr_x_0} = e;
   endtask

   task automatic set_mem(input logic [ADDR_W-1:0] a, input entry_t e);
      store_valid_mem = 1'b1;
      mem_x_addr = a;
      {mem_x_info, mem_x_2, mem_x_1, mem_x_0} = e;
   endtask

   task automatic check_rd(input string tag, input logic [READ_NUM_WIDTH-1:0] num);
      entry_t exp;
      exp = rd_q.pop_front();
      check({tag, "_valid"}, rd_valid, 1'b1);
      check({tag, "_data"}, {rd_info, rd_x2, rd_x1, rd_x0}, exp);
      check({tag, "_tag"}, rd_read_num_o, num);
   endtask

   // Drain lines are checked against the scoreboard on every handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         hs_cnt++;
         if (line_q.size() == 0) begin
            check("drain_extra_line", 1'b1, 1'b0);
         end else begin
            mon_e = line_q.pop_front();
            check("drain_data", out_data, mon_e.dat);
            check("drain_last", out_last, mon_e.last);
            check("drain_tag", out_read_num, mon_e.tag);
         end
      end
   end

   initial begin
      rst = 1'b1; stall = 1'b0; store_valid_curr = 1'b0; store_valid_mem = 1'b0;
      curr_x_0 = '0; curr_x_1 = '0; curr_x_2 = '0; curr_x_info = '0; curr_x_addr = '0;
      mem_x_0 = '0; mem_x_1 = '0; mem_x_2 = '0; mem_x_info = '0; mem_x_addr = '0;
      rd_req = 1'b0; rd_read_num = '0; rd_addr = '0;
      clear_mem = 1'b0; drain_start = 1'b0; drain_read_num = '0; out_ready = 1'b0;
      step(); step();
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_data", {rd_info, rd_x2, rd_x1, rd_x0}, '0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy_done", {drain_busy, drain_done}, 2'b00);
      rst = 1'b0;
      step();

      // Basic read, latency 1
      e1 = '{info: 64'h44, x2: 64'h33, x1: 64'h22, x0: 64'h11};
      set_curr(7'd5, e1);
      step();
      store_valid_curr = 1'b0;
      rd_req = 1'b1; rd_addr = 7'd5; rd_read_num = 6'd3;
      rd_q.push_back(e1);
      step();
      rd_req = 1'b0;
      check_rd("rd1", 6'd3);
      step();
      check("rd_idle_valid", rd_valid, 1'b0);
      check("rd_idle_hold", {rd_info, rd_x2, rd_x1, rd_x0}, e1);

      // Stall freezes read outputs while curr[5] is rewritten
      e2 = mk(64'h5500);
      rd_req = 1'b1; rd_read_num = 6'd4;
      rd_q.push_back(e1);
      step();
      check_rd("rd2", 6'd4);
      stall = 1'b1;
      set_curr(7'd5, e2);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_hold_data", {rd_info, rd_x2, rd_x1, rd_x0}, e1);
         check("stall_hold_meta", {rd_valid, rd_read_num_o}, {1'b1, 6'd4});
      end
      stall = 1'b0; store_valid_curr = 1'b0; rd_read_num = 6'd5;
      rd_q.push_back(e2);
      step();
      rd_req = 1'b0;
      check_rd("rd_after_stall", 6'd5);

      // Same-cycle write and read of curr[9]
      e3 = mk(64'hABCD_0000);
      set_curr(7'd9, e3);
      rd_req = 1'b1; rd_addr = 7'd9; rd_read_num = 6'd6;
      rd_q.push_back(e3);
      step();
      store_valid_curr = 1'b0; rd_req = 1'b0;
      check_rd("rd_bypass", 6'd6);

      // Three-entry drain: two lines, second has a zero upper half
      clear_mem = 1'b1;
      set_mem(7'd0, mk(64'hA0));
      step();
      clear_mem = 1'b0;
      set_mem(7'd1, mk(64'hA1));
      step();
      set_mem(7'd2, mk(64'hA2));
      step();
      store_valid_mem = 1'b0;
      line_q.push_back('{dat: {mk(64'hA1), mk(64'hA0)}, last: 1'b0, tag: 6'd7});
      line_q.push_back('{dat: {256'd0, mk(64'hA2)}, last: 1'b1, tag: 6'd7});
      hs0 = hs_cnt;
      drain_start = 1'b1; drain_read_num = 6'd7; out_ready = 1'b1;
      step();
      drain_start = 1'b0;
      check("d3_busy", drain_busy, 1'b1);
      wait_done(40, seen);
      check("d3_done_seen", seen, 1'b1);
      check("d3_lines", hs_cnt - hs0, 2);
      step();
      check("d3_done_pulse", {drain_done, drain_busy}, 2'b00);

      // Two-entry drain under backpressure; a mid-drain start is ignored
      out_ready = 1'b0;
      set_mem(7'd0, mk(64'hB0));
      step();
      set_mem(7'd1, mk(64'hB1));
      step();
      store_valid_mem = 1'b0;
      line_q.push_back('{dat: {mk(64'hB1), mk(64'hB0)}, last: 1'b1, tag: 6'd8});
      hs0 = hs_cnt;
      drain_start = 1'b1; drain_read_num = 6'd8;
      step();
      drain_start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         seen = out_valid;
      end
      check("d2_valid_seen", seen, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("d2_hold_valid", out_valid, 1'b1);
         check("d2_hold_data", out_data, {mk(64'hB1), mk(64'hB0)});
         drain_start = (i == 1);
         drain_read_num = 6'd9;
      end
      out_ready = 1'b1;
      wait_done(10, seen);
      check("d2_done_seen", seen, 1'b1);
      check("d2_one_transfer", hs_cnt - hs0, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("d2_no_restart", {out_valid, drain_busy}, 2'b00);
      end

      // Empty drain: no line, done within 2 cycles
      hs0 = hs_cnt;
      drain_start = 1'b1; drain_read_num = 6'd10;
      step();
      drain_start = 1'b0;
      check("d0_no_valid", out_valid, 1'b0);
      wait_done(2, seen);
      check("d0_done_seen", seen, 1'b1);
      step();
      check("d0_no_lines", hs_cnt - hs0, 0);
      check("sb_empty", line_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
